// File: rtl/rvv_wb_collector.sv
// Collects per-lane vector results into one register image and offers it as a single writeback.
// Latency: wb_valid rises the cycle after done_in; the image is held stable until wb_ready is seen.
module rvv_wb_collector #(
    parameter VLEN     = 10'd128,
    parameter NB_LANES = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic [4:0]                  vd_addr_in,
    input  logic [2:0]                  vsew,
    input  logic [9:0]                  vl,
    input  logic [(64<<NB_LANES)-1:0]   lane_vd,
    input  logic [(10<<NB_LANES)-1:0]   lane_idx,
    input  logic [(1<<NB_LANES)-1:0]    lane_res,
    input  logic                        done_in,
    input  logic                        wb_ready,
    output logic                        wb_valid,
    output logic [VLEN-1:0]             wb_data,
    output logic [VLEN/8-1:0]           wb_be,
    output logic [4:0]                  wb_addr,
    output logic                        busy
);

    localparam int L      = 1 << NB_LANES;
    localparam int NBYTES = VLEN / 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [VLEN-1:0]     r_data;
    logic [NBYTES-1:0]   r_be;
    logic [4:0]          r_addr;
    logic [2:0]          r_vsew;
    logic [9:0]          r_vl;

    logic                w_latch;
    logic                w_collect;
    logic [15:0]         w_max_elem;
    logic [15:0]         w_limit;
    logic [VLEN-1:0]     w_data_nxt;
    logic [NBYTES-1:0]   w_be_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start)    w_state_nxt = S_COLLECT;
            S_COLLECT: if (done_in)  w_state_nxt = S_COMMIT;
            S_COMMIT:  if (wb_ready) w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_latch   = (r_state == S_IDLE) && start;
        w_collect = (r_state == S_COLLECT);
        wb_valid  = (r_state == S_COMMIT);
        busy      = (r_state != S_IDLE);
    end

    // Element capacity of the register at the latched SEW; codes above 3 are illegal and write nothing.
    always_comb begin
        w_max_elem = 16'(VLEN) >> ({1'b0, r_vsew} + 4'd3);
        if (r_vsew > 3'd3) begin
            w_limit = 16'd0;
        end else if (16'(r_vl) < w_max_elem) begin
            w_limit = 16'(r_vl);
        end else begin
            w_limit = w_max_elem;
        end
    end

    // Byte-wise placement: byte j belongs to element j>>vsew, so idx*SEW is never formed and cannot wrap.
    // Lanes are visited in ascending order, so the higher lane wins a same-index collision.
    always_comb begin
        w_data_nxt = r_data;
        w_be_nxt   = r_be;
        for (int i = 0; i < L; i++) begin
            if (lane_res[i] && (16'(lane_idx[10*i +: 10]) < w_limit)) begin
                for (int j = 0; j < NBYTES; j++) begin
                    if ((16'(j) >> r_vsew[1:0]) == 16'(lane_idx[10*i +: 10])) begin
                        w_data_nxt[8*j +: 8] = lane_vd[64*i + 8*(j & ((1 << r_vsew[1:0]) - 1)) +: 8];
                        w_be_nxt[j]          = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data <= '0;
            r_be   <= '0;
            r_addr <= '0;
            r_vsew <= '0;
            r_vl   <= '0;
        end else if (w_latch) begin
            r_data <= '0;
            r_be   <= '0;
            r_addr <= vd_addr_in;
            r_vsew <= vsew;
            r_vl   <= vl;
        end else if (w_collect) begin
            r_data <= w_data_nxt;
            r_be   <= w_be_nxt;
        end
    end

    assign wb_data = r_data;
    assign wb_be   = r_be;
    assign wb_addr = r_addr;

endmodule

// File: tb/tb_rvv_wb_collector.sv
// Randomized and directed bench for rvv_wb_collector against a byte-array reference model.
module tb_rvv_wb_collector;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [4:0]    vd_addr_in;
    logic [2:0]    vsew;
    logic [9:0]    vl;
    logic [127:0]  lane_vd;
    logic [19:0]   lane_idx;
    logic [1:0]    lane_res;
    logic          done_in;
    logic          wb_ready;
    logic          wb_valid;
    logic [127:0]  wb_data;
    logic [15:0]   wb_be;
    logic [4:0]    wb_addr;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    logic [127:0]  exp_data;
    logic [15:0]   exp_be;
    logic [4:0]    m_addr;
    int            m_sew;
    int            m_vl;

    rvv_wb_collector #(.VLEN(10'd128), .NB_LANES(1)) dut (
        .clk(clk), .resetn(resetn), .start(start), .vd_addr_in(vd_addr_in),
        .vsew(vsew), .vl(vl), .lane_vd(lane_vd), .lane_idx(lane_idx),
        .lane_res(lane_res), .done_in(done_in), .wb_ready(wb_ready),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_be(wb_be),
        .wb_addr(wb_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int limit();
        int cap;
        cap = 16 >> m_sew;
        return (m_vl < cap) ? m_vl : cap;
    endfunction

    task automatic model_lane(input logic res, input int idx, input logic [63:0] d);
        int nb;
        nb = 1 << m_sew;
        if (res && idx < limit()) begin
            for (int k = 0; k < nb; k++) begin
                exp_data[(idx*nb + k)*8 +: 8] = d[k*8 +: 8];
                exp_be[idx*nb + k]            = 1'b1;
            end
        end
    endtask

    task automatic lanes(input logic r0, input int i0, input logic [63:0] d0,
                         input logic r1, input int i1, input logic [63:0] d1, input logic dn);
        lane_res = {r1, r0};
        lane_idx = {10'(i1), 10'(i0)};
        lane_vd  = {d1, d0};
        done_in  = dn;
        model_lane(r0, i0, d0);
        model_lane(r1, i1, d1);
        tick();
        lane_res = '0;
        done_in  = 1'b0;
    endtask

    // Lanes carry junk during the start cycle; it must not land in the image.
    task automatic begin_txn(input logic [4:0] a, input int s, input int n);
        m_addr = a; m_sew = s; m_vl = n;
        exp_data = '0; exp_be = '0;
        vd_addr_in = a; vsew = 3'(s); vl = 10'(n);
        start    = 1'b1;
        lane_res = 2'b11;
        lane_idx = '0;
        lane_vd  = {$urandom, $urandom, $urandom, $urandom};
        tick();
        start = 1'b0;
        lane_res = '0;
        vd_addr_in = 5'($urandom); vsew = 3'($urandom); vl = 10'($urandom);
        chk("busy_collect", busy, 1);
        chk("valid_collect", wb_valid, 0);
    endtask

    task automatic check_image(input string tag);
        chk({tag, "_valid"}, wb_valid, 1);
        chk({tag, "_data"}, wb_data, exp_data);
        chk({tag, "_be"}, wb_be, exp_be);
        chk({tag, "_addr"}, wb_addr, m_addr);
    endtask

    task automatic finish_txn(input int hold, input logic start_in_xfer);
        check_image("commit");
        wb_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            check_image("hold");
        end
        wb_ready = 1'b1;
        start    = start_in_xfer;
        tick();
        wb_ready = 1'b0;
        start    = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_valid", wb_valid, 0);
        tick();
        chk("idle_busy2", busy, 0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; vd_addr_in = '0; vsew = '0; vl = '0;
        lane_vd = '0; lane_idx = '0; lane_res = '0; done_in = 1'b0; wb_ready = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", wb_valid, 0);
        chk("rst_data", wb_data, 0);
        chk("rst_be", wb_be, 0);
        chk("rst_addr", wb_addr, 0);
        resetn = 1'b1;
        tick();

        // done_in and lane activity while idle must do nothing
        done_in = 1'b1; lane_res = 2'b11;
        tick();
        done_in = 1'b0; lane_res = '0;
        chk("idle_done_ignored", busy, 0);
        chk("idle_lane_ignored", wb_be, 0);

        // full byte register, two lanes per cycle
        begin_txn(5'd7, 0, 16);
        for (int k = 0; k < 8; k++)
            lanes(1, 2*k, 64'(8'hA0 + 2*k), 1, 2*k+1, 64'(8'hA0 + 2*k + 1), k == 7);
        chk("byte_full_data", wb_data, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
        chk("byte_full_be", wb_be, 16'hFFFF);
        finish_txn(0, 0);

        // 32-bit elements, vl=3 drops index 3
        begin_txn(5'd3, 2, 3);
        lanes(1, 0, 64'h11111111, 1, 1, 64'h22222222, 0);
        lanes(1, 2, 64'h33333333, 1, 3, 64'h44444444, 1);
        chk("sew32_data", wb_data, 128'h333333332222222211111111);
        chk("sew32_be", wb_be, 16'h0FFF);
        finish_txn(5, 0);

        // same index in both lanes: lane 1 wins
        begin_txn(5'd9, 0, 16);
        lanes(1, 5, 64'h55, 1, 5, 64'hAA, 1);
        chk("collide_data", wb_data, 128'hAA << 40);
        chk("collide_be", wb_be, 16'h0020);
        finish_txn(1, 1);

        // vl=0 still commits with nothing enabled
        begin_txn(5'd21, 1, 0);
        lanes(1, 0, 64'hDEAD, 1, 1, 64'hBEEF, 1);
        chk("vl0_be", wb_be, 16'h0000);
        chk("vl0_addr", wb_addr, 5'd21);
        finish_txn(0, 0);

        // asynchronous reset mid-collection aborts the transaction
        begin_txn(5'd12, 0, 16);
        lanes(1, 0, 64'h01, 0, 0, 64'h0, 0);
        lanes(1, 1, 64'h02, 0, 0, 64'h0, 0);
        lanes(1, 2, 64'h03, 0, 0, 64'h0, 0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_be", wb_be, 0);
        chk("arst_valid", wb_valid, 0);
        tick();
        resetn = 1'b1;
        tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        tick();
        chk("post_rst_valid", wb_valid, 0);
        chk("post_rst_busy", busy, 0);

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            int ncyc;
            begin_txn(5'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 20)));
            ncyc = $urandom_range(1, 10);
            for (int c = 0; c < ncyc; c++) begin
                lanes(1'($urandom), int'($urandom_range(0, limit() + 2)), {$urandom, $urandom},
                      1'($urandom), int'($urandom_range(0, limit() + 2)), {$urandom, $urandom},
                      c == ncyc - 1);
            end
            finish_txn(int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
